spi_apb_arbiter: RTL and testbench
==================================

Name: spi_apb_arbiter

Overview:
- APB master arbiter that shares the single SPI peripheral register port among NUM_REQ on-chip requesters (CPU bridge, DMA, boot loader, ...).
- Round-robin arbitration; each granted request is driven as one complete APB transfer (SETUP → ACCESS → PREADY).
- Read data, completion ack and error status are returned to the winning requester.
- Sits between the requesters and the APB slave side of the SPI peripheral.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 16, APB address width
- TIMEOUT, 255, maximum ACCESS-phase cycles with PREADY low before abort (1..65535)

Ports:
- apb_clk  in  1  system clock, rising edge
- apb_rst  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester transfer request, level
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_wdata  in  NUM_REQ*32  packed write data
- req_strb  in  NUM_REQ*4  packed byte strobes
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- rsp_err  out  1  valid with ack; 1 = timeout abort
- rsp_rdata  out  32  valid with ack; read data (0 for writes/aborts)
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PSTRB  out  4  APB byte strobes
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PREADY  in  1  APB ready from SPI peripheral
- PRDATA  in  32  APB read data from SPI peripheral

Behaviour:
- Reset (apb_rst = 0, asynchronous): state IDLE, all outputs 0, round-robin pointer = 0, timeout counter = 0. Assertion mid-transfer aborts immediately: PSEL/PENABLE drop without waiting for PREADY, and no ack is issued.
- FSM states:
  - IDLE: if any req bit is set, pick the winner, register its addr/write/wdata/strb into the APB outputs, go to SETUP.
  - SETUP: PSEL = 1, PENABLE = 0; unconditionally go to ACCESS next cycle.
  - ACCESS: PSEL = 1, PENABLE = 1. If PREADY = 1: capture PRDATA (reads only), go to DONE. Else increment the counter; when counter == TIMEOUT - 1 and PREADY is still 0, go to DONE with error.
  - DONE: PSEL = PENABLE = 0; ack[winner] = 1 for exactly this cycle; rsp_err and rsp_rdata valid this cycle; go to IDLE.
- PADDR/PWRITE/PWDATA/PSTRB are stable from SETUP through ACCESS; they hold their last values in IDLE/DONE. PSTRB is forced to 0 for reads.
- Latency: req seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycle 2 → DONE/ack at cycle 3 with zero wait states. Each PREADY wait cycle adds one cycle.
- Minimum spacing between transfers is 4 cycles. PSEL is always low for ≥2 cycles (DONE, IDLE) between transfers.
- Arbitration:
  - Search starts at the pointer and proceeds upward, wrapping modulo NUM_REQ; the first set req bit wins.
  - On grant, pointer = winner + 1, wrapping from NUM_REQ-1 to 0.
  - A lone requester can be granted on every transfer.
- Requester contract: hold req and all fields stable until its ack. The arbiter samples the fields only in IDLE at grant.
- Withdrawal: req dropping after grant does not cancel the transfer; it completes and ack is still pulsed.
- Requester re-arbitration: a requester must deassert req in the ack cycle or it re-enters arbitration. The DONE→IDLE ordering guarantees the ack is visible before the next arbitration.
- Timeout abort:
  - PSEL/PENABLE deassert in DONE without PREADY.
  - rsp_err = 1, rsp_rdata = 0.
  - The counter clears on every entry to SETUP.
- rsp_rdata/rsp_err return to 0 in all states other than DONE.
- No combinational path from req or PREADY to any output; all outputs are registered.

Test Plan:
- Reset, then a single req[0] read of addr 0x0004, PREADY=1, PRDATA=0xA5A5_0001 → PSEL rises at cycle 1, PENABLE at cycle 2, ack[0] at cycle 3 with rsp_rdata=0xA5A5_0001, rsp_err=0.
- req[1] write addr 0x0008, wdata 0xDEAD_BEEF, strb 0xF, with PREADY held low 3 cycles → ACCESS lasts 4 cycles with outputs stable; ack[1] pulses once; PWDATA=0xDEAD_BEEF, PSTRB=0xF throughout.
- All four reqs held high continuously → grants in order 0,1,2,3,0,1; each ack pulses exactly once per transfer; PSEL low ≥2 cycles between transfers.
- Pointer at 2, only req[0] and req[1] set → req[0] wins; the next grant goes to req[1].
- TIMEOUT=4 with PREADY stuck low → DONE after 4 ACCESS cycles; ack pulses with rsp_err=1, rsp_rdata=0; the next transfer with PREADY=1 completes normally with err=0.
- apb_rst asserted during ACCESS → PSEL, PENABLE and ack go to 0 asynchronously; after release, no stale ack and the pointer is 0.

Source files
------------

// File: rtl/spi_apb_arbiter.sv
// Round-robin APB master arbiter: shares one SPI peripheral register port
// among NUM_REQ requesters, one full SETUP/ACCESS transfer per grant.
module spi_apb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      apb_clk,
    input  logic                      apb_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_strb,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      rsp_err,
    output logic [31:0]               rsp_rdata,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [31:0]               PWDATA,
    output logic [3:0]                PSTRB,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic                      PREADY,
    input  logic [31:0]               PRDATA
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
    logic [PTR_W-1:0]    r_winner, w_winner_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;

    logic                w_found;
    logic [PTR_W-1:0]    w_win;

    logic [ADDR_W-1:0]   w_paddr_nxt;
    logic                w_pwrite_nxt;
    logic [31:0]         w_pwdata_nxt;
    logic [3:0]          w_pstrb_nxt;
    logic                w_psel_nxt;
    logic                w_penable_nxt;
    logic [NUM_REQ-1:0]  w_ack_nxt;
    logic                w_err_nxt;
    logic [31:0]         w_rdata_nxt;

    // Round-robin search: first set req at or above the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % int'(NUM_REQ)]) begin
                w_found = 1'b1;
                w_win   = PTR_W'((int'(r_ptr) + k) % int'(NUM_REQ));
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_winner_nxt  = r_winner;
        w_cnt_nxt     = r_cnt;
        w_paddr_nxt   = PADDR;
        w_pwrite_nxt  = PWRITE;
        w_pwdata_nxt  = PWDATA;
        w_pstrb_nxt   = PSTRB;
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_ack_nxt     = '0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = ST_SETUP;
                    w_winner_nxt = w_win;
                    w_ptr_nxt    = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
                    w_cnt_nxt    = '0;
                    w_paddr_nxt  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                    w_pwrite_nxt = req_write[w_win];
                    w_pwdata_nxt = req_wdata[int'(w_win)*32 +: 32];
                    w_pstrb_nxt  = req_write[w_win] ? req_strb[int'(w_win)*4 +: 4] : 4'h0;
                    w_psel_nxt   = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = NUM_REQ'(1) << r_winner;
                    w_rdata_nxt = PWRITE ? 32'h0 : PRDATA;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = NUM_REQ'(1) << r_winner;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and all registered outputs
    always_ff @(posedge apb_clk or negedge apb_rst) begin
        if (!apb_rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_winner  <= '0;
            r_cnt     <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            ack       <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_winner  <= w_winner_nxt;
            r_cnt     <= w_cnt_nxt;
            PADDR     <= w_paddr_nxt;
            PWRITE    <= w_pwrite_nxt;
            PWDATA    <= w_pwdata_nxt;
            PSTRB     <= w_pstrb_nxt;
            PSEL      <= w_psel_nxt;
            PENABLE   <= w_penable_nxt;
            ack       <= w_ack_nxt;
            rsp_err   <= w_err_nxt;
            rsp_rdata <= w_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Directed self-checking bench for spi_apb_arbiter (TIMEOUT reduced to 4).
module tb_spi_apb_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned TIMEOUT = 4;

    logic                      apb_clk = 1'b0;
    logic                      apb_rst = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        req_write = '0;
    logic [NUM_REQ*32-1:0]     req_wdata = '0;
    logic [NUM_REQ*4-1:0]      req_strb = '0;
    logic [NUM_REQ-1:0]        ack;
    logic                      rsp_err;
    logic [31:0]               rsp_rdata;
    logic [ADDR_W-1:0]         PADDR;
    logic                      PWRITE;
    logic [31:0]               PWDATA;
    logic [3:0]                PSTRB;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PREADY = 1'b0;
    logic [31:0]               PRDATA = '0;

    int n_checks = 0;
    int n_fail   = 0;

    spi_apb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .apb_clk   (apb_clk),
        .apb_rst   (apb_rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .ack       (ack),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    always #5 apb_clk = ~apb_clk;

    task automatic tick;
        @(posedge apb_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_write[i]                 = w;
        req_wdata[i*32 +: 32]        = d;
        req_strb[i*4 +: 4]           = s;
        req[i]                       = 1'b1;
    endtask

    task automatic test_reset;
        apb_rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({PSEL, PENABLE, ack, rsp_err, rsp_rdata, PADDR, PWRITE, PWDATA, PSTRB} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got psel=%b pen=%b ack=%b err=%b rdata=%h paddr=%h pw=%b pwdata=%h pstrb=%h exp all 0",
                     PSEL, PENABLE, ack, rsp_err, rsp_rdata, PADDR, PWRITE, PWDATA, PSTRB);
        end
        apb_rst = 1'b1;
        tick();
        n_checks++;
        if ({PSEL, PENABLE, ack} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle got psel=%b pen=%b ack=%b exp 0 0 0000", PSEL, PENABLE, ack);
        end
    endtask

    task automatic test_single_read;
        PREADY = 1'b1;
        PRDATA = 32'hA5A5_0001;
        set_req(0, 16'h0004, 1'b0, 32'h1111_2222, 4'hF);
        tick();
        n_checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PSTRB, ack} !== {2'b10, 16'h0004, 1'b0, 4'h0, 4'b0000}) begin
            n_fail++;
            $display("FAIL read_setup got psel=%b pen=%b paddr=%h pw=%b pstrb=%h ack=%b exp 1 0 0004 0 0 0000",
                     PSEL, PENABLE, PADDR, PWRITE, PSTRB, ack);
        end
        tick();
        n_checks++;
        if ({PSEL, PENABLE, ack} !== {2'b11, 4'b0000}) begin
            n_fail++;
            $display("FAIL read_access got psel=%b pen=%b ack=%b exp 1 1 0000", PSEL, PENABLE, ack);
        end
        tick();
        n_checks++;
        if ({ack, rsp_err, rsp_rdata, PSEL, PENABLE} !== {4'b0001, 1'b0, 32'hA5A5_0001, 2'b00}) begin
            n_fail++;
            $display("FAIL read_done got ack=%b err=%b rdata=%h psel=%b pen=%b exp 0001 0 a5a50001 0 0",
                     ack, rsp_err, rsp_rdata, PSEL, PENABLE);
        end
        req[0] = 1'b0;
        tick();
        n_checks++;
        if ({ack, rsp_err, rsp_rdata, PSEL} !== '0) begin
            n_fail++;
            $display("FAIL read_after got ack=%b err=%b rdata=%h psel=%b exp all 0", ack, rsp_err, rsp_rdata, PSEL);
        end
    endtask

    task automatic test_wait_write;
        PREADY = 1'b0;
        PRDATA = 32'h5555_AAAA;
        set_req(1, 16'h0008, 1'b1, 32'hDEAD_BEEF, 4'hF);
        tick();
        n_checks++;
        if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB} !== {2'b10, 16'h0008, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++;
            $display("FAIL write_setup got psel=%b pen=%b paddr=%h pw=%b pwdata=%h pstrb=%h exp 1 0 0008 1 deadbeef f",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, ack} !==
                {2'b11, 16'h0008, 1'b1, 32'hDEAD_BEEF, 4'hF, 4'b0000}) begin
                n_fail++;
                $display("FAIL write_access%0d got psel=%b pen=%b paddr=%h pw=%b pwdata=%h pstrb=%h ack=%b exp 1 1 0008 1 deadbeef f 0000",
                         i, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, ack);
            end
            if (i == 3) PREADY = 1'b1;
            tick();
        end
        n_checks++;
        if ({ack, rsp_err, rsp_rdata, PSEL, PENABLE} !== {4'b0010, 1'b0, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL write_done got ack=%b err=%b rdata=%h psel=%b pen=%b exp 0010 0 00000000 0 0",
                     ack, rsp_err, rsp_rdata, PSEL, PENABLE);
        end
        req[1] = 1'b0;
        tick();
        n_checks++;
        if ({ack, PSEL} !== '0) begin
            n_fail++;
            $display("FAIL write_after got ack=%b psel=%b exp 0000 0", ack, PSEL);
        end
    endtask

    task automatic test_pointer_wrap;
        PREADY = 1'b1;
        PRDATA = 32'h0000_0100;
        set_req(0, 16'h0100, 1'b0, 32'h0, 4'h0);
        set_req(1, 16'h0200, 1'b0, 32'h0, 4'h0);
        tick();
        n_checks++;
        if ({PSEL, PADDR} !== {1'b1, 16'h0100}) begin
            n_fail++;
            $display("FAIL wrap_first_grant got psel=%b paddr=%h exp 1 0100", PSEL, PADDR);
        end
        tick();
        tick();
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_first_ack got ack=%b exp 0001", ack);
        end
        req[0] = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({PSEL, PADDR} !== {1'b1, 16'h0200}) begin
            n_fail++;
            $display("FAIL wrap_second_grant got psel=%b paddr=%h exp 1 0200", PSEL, PADDR);
        end
        tick();
        tick();
        n_checks++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL wrap_second_ack got ack=%b exp 0010", ack);
        end
        req[1] = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        set_req(2, 16'h0300, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({PSEL, PENABLE, PADDR, ack} !== {2'b11, 16'h0300, 4'b0000}) begin
                n_fail++;
                $display("FAIL tmo_access%0d got psel=%b pen=%b paddr=%h ack=%b exp 1 1 0300 0000",
                         i, PSEL, PENABLE, PADDR, ack);
            end
            tick();
        end
        n_checks++;
        if ({ack, rsp_err, rsp_rdata, PSEL, PENABLE} !== {4'b0100, 1'b1, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL tmo_done got ack=%b err=%b rdata=%h psel=%b pen=%b exp 0100 1 00000000 0 0",
                     ack, rsp_err, rsp_rdata, PSEL, PENABLE);
        end
        req[2] = 1'b0;
        tick();
        n_checks++;
        if ({ack, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL tmo_after got ack=%b err=%b exp 0000 0", ack, rsp_err);
        end
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        set_req(3, 16'h0400, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        n_checks++;
        if ({ack, rsp_err, rsp_rdata} !== {4'b1000, 1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL tmo_recover got ack=%b err=%b rdata=%h exp 1000 0 12345678", ack, rsp_err, rsp_rdata);
        end
        req[3] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        PREADY = 1'b0;
        set_req(1, 16'h0500, 1'b1, 32'h0BAD_F00D, 4'h3);
        tick();
        tick();
        tick();
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            n_fail++;
            $display("FAIL rstmid_access got psel=%b pen=%b exp 1 1", PSEL, PENABLE);
        end
        apb_rst = 1'b0;
        #1;
        n_checks++;
        if ({PSEL, PENABLE, ack, PADDR} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async got psel=%b pen=%b ack=%b paddr=%h exp 0 0 0000 0000", PSEL, PENABLE, ack, PADDR);
        end
        req = '0;
        PREADY = 1'b1;
        tick();
        tick();
        apb_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({ack, PSEL} !== '0) begin
                n_fail++;
                $display("FAIL rstmid_stale%0d got ack=%b psel=%b exp 0000 0", i, ack, PSEL);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_ack;
        int         exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        PREADY = 1'b1;
        PRDATA = 32'hCAFE_0000;
        for (int i = 0; i < 4; i++) set_req(i, 16'h1000 + 16'(i), 1'b0, 32'h0, 4'h0);
        for (int t = 0; t < 6; t++) begin
            exp_ack = 4'b0001 << exp_seq[t];
            tick();
            n_checks++;
            if ({PSEL, PENABLE, PADDR} !== {2'b10, 16'h1000 + 16'(exp_seq[t])}) begin
                n_fail++;
                $display("FAIL rr_grant%0d got psel=%b pen=%b paddr=%h exp 1 0 %h",
                         t, PSEL, PENABLE, PADDR, 16'h1000 + 16'(exp_seq[t]));
            end
            tick();
            tick();
            n_checks++;
            if ({ack, PSEL} !== {exp_ack, 1'b0}) begin
                n_fail++;
                $display("FAIL rr_ack%0d got ack=%b psel=%b exp %b 0", t, ack, PSEL, exp_ack);
            end
            tick();
            n_checks++;
            if ({ack, PSEL} !== '0) begin
                n_fail++;
                $display("FAIL rr_gap%0d got ack=%b psel=%b exp 0000 0", t, ack, PSEL);
            end
        end
        req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_wait_write();
        test_pointer_wrap();
        test_timeout();
        test_reset_mid();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
